// File: rtl/ascii_mem_loader_pkg.sv
// Shared types and constants for the ASCII string loader.
package ascii_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        TERM,
        LENW,
        DONE
    } state_t;

    localparam logic [7:0] ASCII_NUL = 8'h00;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    // Length register must hold MAX_LEN-1 as an unsigned count.
    function automatic int len_width(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/ascii_mem_loader_fifo.sv
// Small show-ahead byte FIFO with synchronous clear; dout is valid whenever !empty.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ascii_mem_loader.sv
// Buffers an ASCII byte stream and writes it as a NUL-terminated string plus
// its length into data memory through port B.
module ascii_mem_loader
    import ascii_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0040,
    parameter logic [31:0] LEN_ADDR   = 32'h0000_003C,
    parameter int          MAX_LEN    = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  TERM_CHAR  = ASCII_LF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [7:0]                       char_in,
    input  logic                             char_valid,
    output logic                             char_ready,
    output logic [31:0]                      dataadr_b,
    output logic [31:0]                      writedata_b,
    output logic                             memwrite_b,
    output logic                             busy,
    output logic                             done,
    output logic [len_width(MAX_LEN)-1:0]    len
);
    // state | meaning
    // IDLE  | waiting for start; abort ignored
    // RECV  | popping bytes, one character write per popped byte
    // TERM  | issue the NUL write after the last stored character
    // LENW  | issue the length write to LEN_ADDR
    // DONE  | pulse done and publish len

    localparam int                LEN_W    = len_width(MAX_LEN);
    localparam logic [LEN_W-1:0]  LAST_IDX = LEN_W'(MAX_LEN - 1);

    state_t           state;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] idx_inc;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_clear;
    logic [7:0]       fifo_dout;

    assign char_ready = (state == RECV) && !fifo_full;
    assign fifo_push  = char_valid && char_ready;
    assign fifo_pop   = (state == RECV) && !fifo_empty && !abort;
    assign fifo_clear = (state == IDLE) && start;
    assign idx_inc    = idx + LEN_W'(1);

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (char_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Writes are registered, so each write appears one cycle after the state
    // that decided it; abort therefore only suppresses not-yet-issued writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            dataadr_b   <= '0;
            writedata_b <= '0;
            memwrite_b  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            len         <= '0;
        end else begin
            memwrite_b <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= RECV;
                        busy  <= 1'b1;
                    end
                end
                RECV: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!fifo_empty) begin
                        if (fifo_dout == TERM_CHAR) begin
                            state <= TERM;
                        end else begin
                            memwrite_b  <= 1'b1;
                            dataadr_b   <= BASE_ADDR + 32'(idx);
                            writedata_b <= {24'h0, fifo_dout};
                            idx         <= idx_inc;
                            if (idx_inc == LAST_IDX) begin
                                state <= TERM;
                            end
                        end
                    end
                end
                TERM: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        memwrite_b  <= 1'b1;
                        dataadr_b   <= BASE_ADDR + 32'(idx);
                        writedata_b <= {24'h0, ASCII_NUL};
                        state       <= LENW;
                    end
                end
                LENW: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        memwrite_b  <= 1'b1;
                        dataadr_b   <= LEN_ADDR;
                        writedata_b <= 32'(idx);
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    len   <= idx;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_mem_loader.sv
// Scoreboard bench for ascii_mem_loader: expected port-B writes and done/len
// events are queued by the stimulus and consumed by a negedge monitor.
module tb_ascii_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [31:0] dataadr_b;
    logic [31:0] writedata_b;
    logic        memwrite_b;
    logic        busy;
    logic        done;
    logic [5:0]  len;

    always #5 clk = ~clk;

    ascii_mem_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .dataadr_b   (dataadr_b),
        .writedata_b (writedata_b),
        .memwrite_b  (memwrite_b),
        .busy        (busy),
        .done        (done),
        .len         (len)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    int          exp_len[$];
    wr_t         mon_e;
    int          mon_l;
    int          n_cmp = 0;
    int          n_err = 0;
    int          writes_seen = 0;
    int          done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (memwrite_b) begin
                writes_seen++;
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write (t=%0t)",
                             dataadr_b, writedata_b, $time);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("wr_addr", dataadr_b, mon_e.a);
                    check("wr_data", writedata_b, mon_e.d);
                end
            end
            if (done) begin
                done_seen++;
                if (exp_len.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got len %0d expected no done (t=%0t)", len, $time);
                end else begin
                    mon_l = exp_len.pop_front();
                    check("done_len", 32'(len), 32'(mon_l));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_char(input logic [7:0] c, input int max_wait, output bit acc);
        char_in    = c;
        char_valid = 1'b1;
        acc        = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            if (char_ready) begin
                acc = 1'b1;
                tick();
                break;
            end
            tick();
        end
        char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        bit acc;
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i], 20, acc);
            check("accept", 32'(acc), 32'd1);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_seen >= target) break;
            tick();
        end
        check("done_reached", 32'(done_seen), 32'(target));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_char_ready"}, 32'(char_ready), 32'd0);
        check({tag, "_dataadr"}, dataadr_b, 32'd0);
        check({tag, "_writedata"}, writedata_b, 32'd0);
        check({tag, "_memwrite"}, 32'(memwrite_b), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_len"}, 32'(len), 32'd0);
    endtask

    initial begin
        bit acc;
        int base_w;

        // reset state
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // "HI\n"
        push_wr(32'h40, 32'h48);
        push_wr(32'h41, 32'h49);
        push_wr(32'h42, 32'h00);
        push_wr(32'h3C, 32'd2);
        exp_len.push_back(2);
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        send_str("HI\n");
        wait_done(1, 50);
        repeat (3) tick();
        check("hi_done_count", 32'(done_seen), 32'd1);
        check("hi_len_hold", 32'(len), 32'd2);
        check("hi_queue_empty", 32'(exp_wr.size()), 32'd0);

        // overflow: 40 x 'A', no terminator
        for (int i = 0; i < 31; i++) push_wr(32'h40 + 32'(i), 32'h41);
        push_wr(32'h5F, 32'h00);
        push_wr(32'h3C, 32'd31);
        exp_len.push_back(31);
        pulse_start();
        for (int i = 0; i < 40; i++) send_char(8'h41, 4, acc);
        wait_done(2, 100);
        char_valid = 1'b1;
        char_in    = 8'h41;
        tick();
        check("ovf_ready_low", 32'(char_ready), 32'd0);
        char_valid = 1'b0;
        check("ovf_len", 32'(len), 32'd31);
        check("ovf_queue_empty", 32'(exp_wr.size()), 32'd0);

        // back-to-back burst of 6 then LF: accepted every cycle, nothing lost
        for (int i = 0; i < 6; i++) push_wr(32'h40 + 32'(i), 32'h31 + 32'(i));
        push_wr(32'h46, 32'h00);
        push_wr(32'h3C, 32'd6);
        exp_len.push_back(6);
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            send_char(8'h31 + 8'(i), 1, acc);
            check("burst_accept", 32'(acc), 32'd1);
        end
        send_str("\n");
        wait_done(3, 50);
        check("burst_queue_empty", 32'(exp_wr.size()), 32'd0);

        // abort after three stored characters
        push_wr(32'h40, 32'h61);
        push_wr(32'h41, 32'h62);
        push_wr(32'h42, 32'h63);
        base_w = writes_seen;
        pulse_start();
        send_str("abc");
        for (int i = 0; i < 20; i++) begin
            if (writes_seen >= base_w + 3) break;
            tick();
        end
        check("abort_writes_seen", 32'(writes_seen - base_w), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy_low", 32'(busy), 32'd0);
        check("abort_ready_low", 32'(char_ready), 32'd0);
        repeat (10) tick();
        check("abort_no_done", 32'(done_seen), 32'd3);
        check("abort_len_kept", 32'(len), 32'd6);
        check("abort_queue_empty", 32'(exp_wr.size()), 32'd0);

        // asynchronous reset in RECV with a write about to be registered
        pulse_start();
        send_char(8'h78, 4, acc);
        check("rst_accept", 32'(acc), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("rst_no_write", 32'(memwrite_b), 32'd0);
        end
        tick();
        check("rst_idle", 32'(busy), 32'd0);

        // start pulsed again during RECV is ignored
        push_wr(32'h40, 32'h4F);
        push_wr(32'h41, 32'h4B);
        push_wr(32'h42, 32'h00);
        push_wr(32'h3C, 32'd2);
        exp_len.push_back(2);
        pulse_start();
        send_str("O");
        pulse_start();
        send_str("K\n");
        wait_done(4, 50);
        repeat (6) tick();
        check("restart_done_count", 32'(done_seen), 32'd4);
        check("restart_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("restart_busy_low", 32'(busy), 32'd0);
        check("restart_len", 32'(len), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
